// File: rtl/dram_seq_ctrl.sv
// Sequencer that owns the image DRAM port: LOAD host bytes, RUN the CPU, DUMP the result region.
// Optional build macro DUMP_CHECKSUM_EN adds a 16-bit running sum of dumped bytes (dump_sum).
module dram_seq_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int LOAD_WORDS = 65536,
    parameter int DUMP_BASE  = 0,
    parameter int DUMP_WORDS = 16384
) (
    input  logic              clka,
    input  logic              rstn,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              cpu_enable,
    input  logic              cpu_finish,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [15:0]       dump_sum
`endif
);

    // Handshakes: a byte moves on ld_valid && ld_ready and on out_valid && out_ready,
    // in the cycle both are high at the rising edge; valid may not drop while waiting.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_RUN       = 3'd2,
        S_DUMP_RD   = 3'd3,
        S_DUMP_WAIT = 3'd4,
        S_DUMP_OUT  = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LD_LAST   = ADDR_W'(LOAD_WORDS - 1);
    localparam logic [ADDR_W-1:0] DP_LAST   = ADDR_W'(DUMP_WORDS - 1);
    localparam logic [ADDR_W-1:0] DP_BASE_A = ADDR_W'(DUMP_BASE);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [ADDR_W-1:0]   dp_cnt_q, dp_cnt_d;
    logic                cpu_enable_q, cpu_enable_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
`ifdef DUMP_CHECKSUM_EN
    logic [15:0]         sum_q, sum_d;
`endif

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            ld_cnt_q     <= '0;
            dp_cnt_q     <= '0;
            cpu_enable_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
`ifdef DUMP_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ld_cnt_q     <= ld_cnt_d;
            dp_cnt_q     <= dp_cnt_d;
            cpu_enable_q <= cpu_enable_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
`ifdef DUMP_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        dp_cnt_d    = dp_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef DUMP_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        ld_ready    = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    ld_cnt_d = '0;
                    dp_cnt_d = '0;
`ifdef DUMP_CHECKSUM_EN
                    sum_d    = '0;
`endif
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_addr  = ld_cnt_q;
                    mem_wdata = ld_data;
                    mem_wr    = 1'b1;
                    ld_cnt_d  = ld_cnt_q + 1'b1;
                    if (ld_cnt_q == LD_LAST) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // The CPU owns the port outright; only here can its strobes reach DRAM.
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_wr    = cpu_wr;
                mem_rd    = cpu_rd;
                if (cpu_finish) begin
                    state_d = S_DUMP_RD;
                end
            end
            S_DUMP_RD: begin
                mem_addr = DP_BASE_A + dp_cnt_q;
                mem_rd   = 1'b1;
                state_d  = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                out_data_d  = mem_rdata;
                out_valid_d = 1'b1;
                state_d     = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    dp_cnt_d    = dp_cnt_q + 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    sum_d       = sum_q + {{(16-DATA_W){1'b0}}, out_data_q};
`endif
                    state_d     = (dp_cnt_q == DP_LAST) ? S_DONE : S_DUMP_RD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cpu_enable_d = (state_d == S_RUN);
    end

    assign cpu_enable = cpu_enable_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign state_dbg  = state_q;
`ifdef DUMP_CHECKSUM_EN
    assign dump_sum   = sum_q;
`endif

endmodule

// File: tb/tb_dram_seq_ctrl.sv
// Directed bench for dram_seq_ctrl: small LOAD/DUMP sizes, behavioural DRAM, hand-computed expectations.
module tb_dram_seq_ctrl;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // ---------------- clock / reset ----------------
  logic clka = 1'b0;
  logic rstn;
  always #5 clka = ~clka;

  logic              start, ld_valid, ld_ready, cpu_enable, cpu_finish;
  logic [DATA_W-1:0] ld_data, cpu_wdata, mem_wdata, mem_rdata, out_data;
  logic [ADDR_W-1:0] cpu_addr, mem_addr;
  logic              cpu_wr, cpu_rd, mem_wr, mem_rd, out_valid, out_ready, busy, done;
  logic [2:0]        state_dbg;
`ifdef DUMP_CHECKSUM_EN
  logic [15:0]       dump_sum;
`endif

  dram_seq_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_WORDS(4), .DUMP_BASE(8), .DUMP_WORDS(2)
  ) dut (
    .clka(clka), .rstn(rstn), .start(start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .cpu_enable(cpu_enable), .cpu_finish(cpu_finish), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done), .state_dbg(state_dbg)
`ifdef DUMP_CHECKSUM_EN
    , .dump_sum(dump_sum)
`endif
  );

  // ---------------- DRAM model ----------------
  logic [DATA_W-1:0] dram [0:65535];
  int n_wr = 0;
  always @(posedge clka) begin
    if (mem_wr) begin
      dram[mem_addr] <= mem_wdata;
      n_wr <= n_wr + 1;
    end
    if (mem_rd) mem_rdata <= dram[mem_addr];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(negedge clka); start = 1'b1;
    @(negedge clka); start = 1'b0;
    #1;
    check("start_state", state_dbg, 3'd1);
    check("start_ld_ready", ld_ready, 1'b1);
    check("start_busy", busy, 1'b1);
    check("start_done", done, 1'b0);
  endtask

  task automatic load_byte(input int idx, input logic [7:0] b, input bit gap, input bit poke);
    if (gap) begin
      if (poke) begin
        cpu_wr = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 8'hEE; start = 1'b1;
      end
      #1;
      check("gap_no_wr", mem_wr, 1'b0);
      @(negedge clka);
      cpu_wr = 1'b0; start = 1'b0;
      #1;
      check("gap_state", state_dbg, 3'd1);
    end
    ld_valid = 1'b1; ld_data = b;
    #1;
    check("ld_wr", mem_wr, 1'b1);
    check("ld_addr", mem_addr, idx);
    check("ld_wdata", mem_wdata, b);
    @(negedge clka);
    ld_valid = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] base, input bit poke);
    int n0;
    n0 = n_wr;
    for (int i = 0; i < 4; i++) load_byte(i, base + 8'(i), (i % 2) == 1, poke && (i == 1));
    #1;
    check("run_state", state_dbg, 3'd2);
    check("run_cpu_enable", cpu_enable, 1'b1);
    check("run_ld_ready", ld_ready, 1'b0);
    check("load_wr_count", n_wr - n0, 4);
    for (int i = 0; i < 4; i++) check("load_dram", dram[i], base + 8'(i));
    ld_valid = 1'b1; ld_data = 8'h99;
    #1;
    check("run_ld_ignored", mem_wr, 1'b0);
    ld_valid = 1'b0;
  endtask

  task automatic do_run(input logic [7:0] b0, input logic [7:0] b1);
    @(negedge clka);
    cpu_addr = 16'd8; cpu_wdata = b0; cpu_wr = 1'b1;
    #1;
    check("cpu_pass_wr", mem_wr, 1'b1);
    check("cpu_pass_addr", mem_addr, 16'd8);
    @(negedge clka);
    cpu_addr = 16'd9; cpu_wdata = b1;
    @(negedge clka);
    cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_finish = 1'b1;
    #1;
    check("finish_pre_enable", cpu_enable, 1'b1);
    @(negedge clka);
    cpu_finish = 1'b0;
    #1;
    check("finish_enable", cpu_enable, 1'b0);
    check("dump_rd_state", state_dbg, 3'd3);
    check("dump_rd0", mem_rd, 1'b1);
    check("dump_addr0", mem_addr, 16'd8);
    check("cpu_dram8", dram[8], b0);
    check("cpu_dram9", dram[9], b1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clka);
      n++;
    end
    check("valid_seen", out_valid, 1'b1);
  endtask

  task automatic do_dump(input logic [7:0] b0, input logic [7:0] b1, input int stall);
    int n;
    wait_valid(n);
    check("dump_lat0", n, 2);
    check("out_byte0", out_data, b0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clka);
      #1;
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, b0);
      check("stall_no_rd", mem_rd, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clka);
    out_ready = 1'b0;
    #1;
    check("dump_rd1", mem_rd, 1'b1);
    check("dump_addr1", mem_addr, 16'd9);
    check("hs_valid_low", out_valid, 1'b0);
    wait_valid(n);
    check("dump_lat1", n, 2);
    check("out_byte1", out_data, b1);
    out_ready = 1'b1;
    @(negedge clka);
    out_ready = 1'b0;
    #1;
    check("done", done, 1'b1);
    check("done_busy", busy, 1'b0);
    check("done_valid", out_valid, 1'b0);
    check("done_state", state_dbg, 3'd6);
`ifdef DUMP_CHECKSUM_EN
    check("dump_sum", dump_sum, 16'(b0) + 16'(b1));
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rstn = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    cpu_finish = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clka);
    #1;
    check("rst_state", state_dbg, 3'd0);
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_cpu_enable", cpu_enable, 1'b0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, 16'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rstn = 1'b1;

    // Pass 1: gapped load with CPU strobe and start pokes, 5-cycle consumer stall
    do_start();
    do_load(8'd5, 1'b1);
    do_run(8'h11, 8'h22);
    do_dump(8'h11, 8'h22, 5);

    // Pass 2: restart from DONE, reset while a dump byte is pending
    do_start();
    do_load(8'd1, 1'b0);
    do_run(8'hAA, 8'hBB);
    wait_valid(n);
    #3;
    rstn = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_data", out_data, 8'h00);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_state", state_dbg, 3'd0);
    check("rst_mid_mem_rd", mem_rd, 1'b0);
    check("rst_mid_cpu_en", cpu_enable, 1'b0);
    @(negedge clka);
    rstn = 1'b1;

    // Pass 3: fresh pass from IDLE reloads at address 0; checksum carry case
    do_start();
    do_load(8'd5, 1'b0);
    do_run(8'hFF, 8'h02);
    do_dump(8'hFF, 8'h02, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dram_seq_ctrl.md
Name: dram_seq_ctrl

Overview:
- Top-level sequencer and owner of the single-port image DRAM used by downsampling_CPU.
- Phases:
  - LOAD: streams the input image from a host byte source into DRAM at auto-incrementing addresses.
  - RUN: hands the DRAM port to downsampling_CPU and waits for its finish.
  - DUMP: streams the result region out over a valid/ready byte interface.
- Exactly one requester drives the DRAM port in any cycle.

Parameters:
- ADDR_W, 16, DRAM address width.
- DATA_W, 8, DRAM data width.
- LOAD_WORDS, 65536, bytes written in LOAD, at addresses 0..LOAD_WORDS-1.
- DUMP_BASE, 0, first DRAM address read in DUMP.
- DUMP_WORDS, 16384, bytes read in DUMP, at addresses DUMP_BASE..DUMP_BASE+DUMP_WORDS-1.

Ports:
- clka in 1: system clock, rising edge.
- rstn in 1: asynchronous active-low reset.
- start in 1: one-cycle pulse that begins a LOAD→RUN→DUMP pass.
- ld_valid in 1: host byte valid.
- ld_data in DATA_W: host byte.
- ld_ready out 1: controller accepts the host byte.
- cpu_enable out 1: enable to downsampling_CPU.
- cpu_finish in 1: finish from downsampling_CPU (level).
- cpu_addr in ADDR_W: CPU DRAM address.
- cpu_wdata in DATA_W: CPU write data.
- cpu_wr in 1: CPU write strobe.
- cpu_rd in 1: CPU read strobe.
- mem_addr out ADDR_W: DRAM address.
- mem_wdata out DATA_W: DRAM write data.
- mem_wr out 1: DRAM write.
- mem_rd out 1: DRAM read.
- mem_rdata in DATA_W: DRAM read data, valid 1 cycle after mem_rd.
- out_valid out 1: dump byte valid.
- out_data out DATA_W: dump byte.
- out_ready in 1: dump consumer ready.
- busy out 1: high in every state except IDLE and DONE.
- done out 1: high in DONE.

Behaviour:
- Reset: rstn low asynchronously forces state=IDLE and all counters to 0. All outputs are 0: ld_ready, cpu_enable, mem_* , out_valid, out_data, busy, done. Reset mid-phase abandons the pass; no partial state survives.
- States: IDLE, LOAD, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE.
- IDLE/DONE: start=1 → LOAD and clears ld_cnt and dp_cnt. start is ignored in all other states.
- LOAD:
  - ld_ready=1.
  - On ld_valid&&ld_ready (combinational port mux): mem_addr=ld_cnt, mem_wdata=ld_data, mem_wr=1, and ld_cnt increments.
  - The handshake on ld_cnt==LOAD_WORDS-1 moves to RUN next cycle. Bytes presented after that are not accepted (ld_ready=0).
  - ld_valid=0 stalls with no memory access.
- RUN:
  - cpu_enable=1 (registered, asserted from the first RUN cycle).
  - mem_* = cpu_* passthrough; the controller generates no accesses.
  - cpu_finish=1 sampled in RUN → DUMP_RD. cpu_enable drops the same edge.
  - cpu_finish is ignored outside RUN.
- DUMP_RD: mem_addr=DUMP_BASE+dp_cnt (ADDR_W wrap-around arithmetic), mem_rd=1; next state DUMP_WAIT.
- DUMP_WAIT: out_data<=mem_rdata, out_valid<=1; next state DUMP_OUT.
- DUMP_OUT:
  - out_valid and out_data hold stable until out_ready=1.
  - On handshake: out_valid<=0 and dp_cnt increments.
  - If dp_cnt==DUMP_WORDS-1 → DONE, else → DUMP_RD.
- Throughput: 3 cycles per byte with out_ready tied high.
- DONE: done=1 and busy=0 until start or reset.
- Outside LOAD/RUN/DUMP_RD, mem_wr=mem_rd=0 and mem_addr/mem_wdata=0.
- A CPU strobe while not in RUN never reaches DRAM.

Optional Feature:
- Macro DUMP_CHECKSUM_EN.
- Defined:
  - Adds output dump_sum (16 bits), cleared at reset and on start.
  - On each DUMP_OUT handshake: dump_sum <= dump_sum + zero-extended out_data, mod 2^16.
  - Final value is stable in DONE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- LOAD_WORDS=4, DUMP_WORDS=2, DUMP_BASE=8, start, host sends 5,6,7,8 with ld_valid gaps → DRAM writes addr 0..3 = 5..8, one mem_wr per accepted byte, RUN entered after 4th handshake, cpu_enable=1.
- In RUN, CPU writes addr 8=0x11, addr 9=0x22 then raises cpu_finish → cpu_enable falls, out bytes 0x11 then 0x22, then done=1.
- out_ready held low 5 cycles during DUMP_OUT → out_valid/out_data stable, dp_cnt unchanged, no new mem_rd.
- cpu_wr=1 and start pulsed during LOAD → no CPU write reaches DRAM, start ignored, ld_cnt unaffected.
- rstn low mid-DUMP → all outputs 0 immediately. New start reloads from address 0.
- DUMP_CHECKSUM_EN with dump bytes 0xFF,0x02 → dump_sum=0x0101 in DONE.
